// File: rtl/q_update_ctrl.sv
// Sequencer for one double-agent Bellman update: read rows S and S', issue to the updater, write Qnew back.
// Optional QCTRL_PERF_CNT_EN adds perf_upd_cnt / perf_busy_cnt counters and their ports.
module q_update_ctrl #(
    parameter int ST_W    = 4,
    parameter int UPD_LAT = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [ST_W-1:0] req_s,
    input  logic [ST_W-1:0] req_sn,
    input  logic [1:0]      req_a_A,
    input  logic [1:0]      req_a_B,
    input  logic [31:0]     req_r,
    input  logic [2:0]      req_alpha,
    input  logic [2:0]      req_gamma,
    output logic [ST_W-1:0] qt_raddr,
    input  logic [127:0]    qt_rdata_A,
    input  logic [127:0]    qt_rdata_B,
    output logic            qt_we,
    output logic [ST_W-1:0] qt_waddr,
    output logic [1:0]      qt_wact_A,
    output logic [1:0]      qt_wact_B,
    output logic [31:0]     qt_wdata_A,
    output logic [31:0]     qt_wdata_B,
    output logic [31:0]     upd_q0_A,
    output logic [31:0]     upd_q1_A,
    output logic [31:0]     upd_q2_A,
    output logic [31:0]     upd_q3_A,
    output logic [31:0]     upd_q0_B,
    output logic [31:0]     upd_q1_B,
    output logic [31:0]     upd_q2_B,
    output logic [31:0]     upd_q3_B,
    output logic [1:0]      upd_a_A,
    output logic [1:0]      upd_a_B,
    output logic [1:0]      upd_amax_A,
    output logic [1:0]      upd_amax_B,
    output logic [31:0]     upd_r,
    output logic [2:0]      upd_alpha,
    output logic [2:0]      upd_gamma,
    input  logic [31:0]     upd_qnew_A,
    input  logic [31:0]     upd_qnew_B,
    output logic            done,
    output logic [1:0]      amax_A,
    output logic [1:0]      amax_B,
    output logic [2:0]      dbg_state
`ifdef QCTRL_PERF_CNT_EN
    ,
    output logic [31:0]     perf_upd_cnt,
    output logic [31:0]     perf_busy_cnt
`endif
);
    // Handshake: a request is taken on a rising edge where req_valid && req_ready;
    // req_ready is high only in IDLE, so inputs presented while busy are simply not taken.
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RD_S  = 3'd1;
    localparam logic [2:0] S_RD_SN = 3'd2;
    localparam logic [2:0] S_ISSUE = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_WB    = 3'd5;

    localparam int CNT_W = (UPD_LAT > 2) ? $clog2(UPD_LAT - 1) : 1;

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [ST_W-1:0]  r_s;
    logic [ST_W-1:0]  r_sn;
    logic [ST_W-1:0]  r_raddr;
    logic [1:0]       r_a_A;
    logic [1:0]       r_a_B;
    logic [31:0]      r_r;
    logic [2:0]       r_alpha;
    logic [2:0]       r_gamma;
    logic [1:0]       r_amax_A;
    logic [1:0]       r_amax_B;
    logic [1:0]       w_amax_A;
    logic [1:0]       w_amax_B;

    // Signed argmax; the strict '>' keeps the lowest index on ties.
    function automatic logic [1:0] argmax(input logic [127:0] row);
        logic signed [31:0] best;
        logic [1:0]         idx;
        best = row[31:0];
        idx  = 2'd0;
        for (int i = 1; i < 4; i++) begin
            if ($signed(row[i*32 +: 32]) > best) begin
                best = row[i*32 +: 32];
                idx  = 2'(i);
            end
        end
        return idx;
    endfunction

    assign w_amax_A = argmax(qt_rdata_A);
    assign w_amax_B = argmax(qt_rdata_B);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_s      <= '0;
            r_sn     <= '0;
            r_raddr  <= '0;
            r_a_A    <= '0;
            r_a_B    <= '0;
            r_r      <= '0;
            r_alpha  <= '0;
            r_gamma  <= '0;
            r_amax_A <= '0;
            r_amax_B <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_s     <= req_s;
                        r_sn    <= req_sn;
                        r_a_A   <= req_a_A;
                        r_a_B   <= req_a_B;
                        r_r     <= req_r;
                        r_alpha <= req_alpha;
                        r_gamma <= req_gamma;
                        r_raddr <= req_s;
                        r_state <= S_RD_S;
                    end
                end
                S_RD_S: begin
                    r_raddr <= r_sn;
                    r_state <= S_RD_SN;
                end
                S_RD_SN: r_state <= S_ISSUE;
                S_ISSUE: begin
                    r_amax_A <= w_amax_A;
                    r_amax_B <= w_amax_B;
                    r_cnt    <= CNT_W'(UPD_LAT - 2);
                    r_state  <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_cnt == '0) r_state <= S_WB;
                    else             r_cnt   <= r_cnt - 1'b1;
                end
                S_WB:    r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = (r_state == S_IDLE);
    assign qt_raddr   = r_raddr;
    assign qt_we      = (r_state == S_WB);
    assign done       = (r_state == S_WB);
    assign qt_waddr   = r_s;
    assign qt_wact_A  = r_a_A;
    assign qt_wact_B  = r_a_B;
    assign qt_wdata_A = upd_qnew_A;
    assign qt_wdata_B = upd_qnew_B;
    assign {upd_q3_A, upd_q2_A, upd_q1_A, upd_q0_A} = qt_rdata_A;
    assign {upd_q3_B, upd_q2_B, upd_q1_B, upd_q0_B} = qt_rdata_B;
    assign upd_a_A    = r_a_A;
    assign upd_a_B    = r_a_B;
    // Amax is only known while row S' sits on rdata; afterwards the registered copy holds it.
    assign upd_amax_A = (r_state == S_ISSUE) ? w_amax_A : r_amax_A;
    assign upd_amax_B = (r_state == S_ISSUE) ? w_amax_B : r_amax_B;
    assign upd_r      = r_r;
    assign upd_alpha  = r_alpha;
    assign upd_gamma  = r_gamma;
    assign amax_A     = r_amax_A;
    assign amax_B     = r_amax_B;
    assign dbg_state  = r_state;

`ifdef QCTRL_PERF_CNT_EN
    logic [31:0] r_perf_upd;
    logic [31:0] r_perf_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_upd  <= '0;
            r_perf_busy <= '0;
        end else begin
            if (r_state == S_WB)   r_perf_upd  <= r_perf_upd + 32'd1;
            if (r_state != S_IDLE) r_perf_busy <= r_perf_busy + 32'd1;
        end
    end

    assign perf_upd_cnt  = r_perf_upd;
    assign perf_busy_cnt = r_perf_busy;
`else
    // Counters absent in this build.
`endif

endmodule
